// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encoding and bus-level constants for the I2C register target
package i2c_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 3'd0,
      ST_ADDR     = 3'd1,
      ST_ADDR_ACK = 3'd2,
      ST_RX_PTR   = 3'd3,
      ST_RX_DATA  = 3'd4,
      ST_TX_DATA  = 3'd5,
      ST_TX_ACK   = 3'd6
   } state_t;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// rtl/i2c_line_sync.sv - SDA/SCL synchronisers with edge, START and STOP detection
module i2c_line_sync (
   input  logic clock,
   input  logic reset,
   input  logic sda_pin,
   input  logic scl_pin,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start_det,
   output logic stop_det
);

   logic [1:0] sda_sync;
   logic [1:0] scl_sync;
   logic       sda_last;
   logic       scl_last;
   logic       scl_s;

   // Flops reset to 1 so an idle (pulled-up) bus produces no spurious edges.
   always_ff @(posedge clock) begin
      if (reset) begin
         sda_sync <= 2'b11;
         scl_sync <= 2'b11;
         sda_last <= 1'b1;
         scl_last <= 1'b1;
      end else begin
         sda_sync <= {sda_sync[0], sda_pin};
         scl_sync <= {scl_sync[0], scl_pin};
         sda_last <= sda_sync[1];
         scl_last <= scl_sync[1];
      end
   end

   assign sda_s     = sda_sync[1];
   assign scl_s     = scl_sync[1];
   assign scl_rise  = scl_s & ~scl_last;
   assign scl_fall  = ~scl_s & scl_last;
   assign start_det = scl_s & sda_last & ~sda_s;
   assign stop_det  = scl_s & ~sda_last & sda_s;

endmodule

// File: rtl/i2c_slave_regfile.sv
// rtl/i2c_slave_regfile.sv - I2C target exposing a DEPTH x 8 register file with auto-increment pointer
module i2c_slave_regfile
   import i2c_pkg::*;
#(
   parameter logic [6:0] MY_ADDRESS = 7'h11,
   parameter int         DEPTH      = 16,
   parameter int         PTR_W      = 4,
   parameter logic [7:0] REG_INIT   = 8'h00
) (
   input  logic             clock,
   input  logic             reset,
   inout  wire              SDA,
   inout  wire              SCL,
   input  logic [PTR_W-1:0] host_addr,
   input  logic             host_we,
   input  logic [7:0]       host_wdata,
   output logic [7:0]       host_rdata,
   output logic             wr_strobe,
   output logic [PTR_W-1:0] wr_addr,
   output logic             busy
);

   state_t           state, state_n;
   logic [3:0]       bit_cnt, bit_cnt_n;
   logic [7:0]       shreg, shreg_n;
   logic             sda_oe, sda_oe_n;
   logic [PTR_W-1:0] ptr, ptr_n;
   logic             busy_n;
   logic             commit;
   logic [7:0]       regs [DEPTH];

   logic sda_s, scl_rise, scl_fall, start_det, stop_det;

   assign SDA        = sda_oe ? 1'b0 : 1'bz;
   assign SCL        = 1'bz;
   assign host_rdata = regs[host_addr];

   i2c_line_sync u_sync (
      .clock     (clock),
      .reset     (reset),
      .sda_pin   (SDA),
      .scl_pin   (SCL),
      .sda_s     (sda_s),
      .scl_rise  (scl_rise),
      .scl_fall  (scl_fall),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      shreg_n   = shreg;
      sda_oe_n  = sda_oe;
      ptr_n     = ptr;
      busy_n    = busy;
      commit    = 1'b0;
      if (start_det) begin
         state_n   = ST_ADDR;
         bit_cnt_n = 4'd0;
         sda_oe_n  = 1'b0;
      end else if (stop_det) begin
         state_n  = ST_IDLE;
         busy_n   = 1'b0;
         sda_oe_n = 1'b0;
      end else begin
         case (state)
            ST_IDLE: sda_oe_n = 1'b0;
            ST_ADDR: begin
               if (scl_rise) begin
                  shreg_n   = {shreg[6:0], sda_s};
                  bit_cnt_n = bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) state_n = ST_ADDR_ACK;
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  bit_cnt_n = 4'd0;
                  if (shreg[7:1] == MY_ADDRESS) begin
                     sda_oe_n = 1'b1;
                     busy_n   = 1'b1;
                     if (shreg[0]) begin
                        state_n = ST_TX_DATA;
                        shreg_n = regs[ptr];
                     end else begin
                        state_n = ST_RX_PTR;
                     end
                  end else begin
                     state_n = ST_IDLE;
                     busy_n  = 1'b0;
                  end
               end
            end
            // While sda_oe is set we are in the ACK clock: its rise is not data.
            ST_RX_PTR, ST_RX_DATA: begin
               if (scl_rise && !sda_oe) begin
                  shreg_n = {shreg[6:0], sda_s};
                  if (bit_cnt != 4'd8) bit_cnt_n = bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (sda_oe) begin
                     sda_oe_n = 1'b0;
                  end else if (bit_cnt == 4'd8) begin
                     sda_oe_n  = 1'b1;
                     bit_cnt_n = 4'd0;
                     if (state == ST_RX_PTR) begin
                        ptr_n   = shreg[PTR_W-1:0];
                        state_n = ST_RX_DATA;
                     end else begin
                        commit = 1'b1;
                        ptr_n  = ptr + 1'b1;
                     end
                  end
               end
            end
            ST_TX_DATA: begin
               if (scl_fall) begin
                  if (bit_cnt != 4'd8) begin
                     sda_oe_n  = ~shreg[7];
                     shreg_n   = {shreg[6:0], 1'b0};
                     bit_cnt_n = bit_cnt + 4'd1;
                  end else begin
                     sda_oe_n = 1'b0;
                     ptr_n    = ptr + 1'b1;
                     state_n  = ST_TX_ACK;
                  end
               end
            end
            ST_TX_ACK: begin
               if (scl_rise) begin
                  if (sda_s == I2C_ACK) begin
                     state_n   = ST_TX_DATA;
                     shreg_n   = regs[ptr];
                     bit_cnt_n = 4'd0;
                  end else begin
                     state_n = ST_IDLE;
                  end
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= ST_IDLE;
         bit_cnt   <= 4'd0;
         shreg     <= 8'h00;
         sda_oe    <= 1'b0;
         ptr       <= '0;
         busy      <= 1'b0;
         wr_strobe <= 1'b0;
         wr_addr   <= '0;
         for (int i = 0; i < DEPTH; i++) regs[i] <= REG_INIT;
      end else begin
         state     <= state_n;
         bit_cnt   <= bit_cnt_n;
         shreg     <= shreg_n;
         sda_oe    <= sda_oe_n;
         ptr       <= ptr_n;
         busy      <= busy_n;
         wr_strobe <= commit;
         if (commit) wr_addr <= ptr;
         // I2C commit is applied last so it wins a same-index collision.
         if (host_we) regs[host_addr] <= host_wdata;
         if (commit) regs[ptr] <= shreg;
      end
   end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// tb/tb_i2c_slave_regfile.sv - self-checking bench for i2c_slave_regfile
module tb_i2c_slave_regfile;

   logic       clock = 1'b0;
   logic       reset;
   logic       m_sda = 1'b1;
   logic       m_scl = 1'b1;
   wire        sda_bus;
   wire        scl_bus;
   logic [3:0] host_addr;
   logic       host_we;
   logic [7:0] host_wdata;
   logic [7:0] host_rdata;
   logic       wr_strobe;
   logic [3:0] wr_addr;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int strobe_cnt = 0;
   logic nm_watch = 1'b0;
   logic nm_pull = 1'b0;
   logic nm_busy = 1'b0;

   typedef struct {
      logic [3:0] addr;
      logic [7:0] data;
   } wr_exp_t;
   wr_exp_t    exp_q[$];
   logic [7:0] rd_q[$];

   typedef struct {
      logic       we;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp;
   } host_vec_t;

   always #5 clock = ~clock;

   pullup (sda_bus);
   pullup (scl_bus);
   assign sda_bus = m_sda ? 1'bz : 1'b0;
   assign scl_bus = m_scl ? 1'bz : 1'b0;

   i2c_slave_regfile #(
      .MY_ADDRESS (7'h11),
      .DEPTH      (16),
      .PTR_W      (4),
      .REG_INIT   (8'h00)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .SDA        (sda_bus),
      .SCL        (scl_bus),
      .host_addr  (host_addr),
      .host_we    (host_we),
      .host_wdata (host_wdata),
      .host_rdata (host_rdata),
      .wr_strobe  (wr_strobe),
      .wr_addr    (wr_addr),
      .busy       (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (nm_watch && m_sda && sda_bus === 1'b0) nm_pull = 1'b1;
      if (nm_watch && busy) nm_busy = 1'b1;
      if (wr_strobe === 1'b1) begin
         wr_exp_t e;
         strobe_cnt++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr_strobe: got wr_addr %h expected no strobe", wr_addr);
         end else begin
            e = exp_q.pop_front();
            chk("wr_addr", {28'd0, wr_addr}, {28'd0, e.addr});
         end
      end
   end

   task automatic wait_q();
      repeat (5) @(posedge clock);
      #1;
   endtask

   task automatic send_bit(input logic b);
      m_sda = b;
      wait_q();
      m_scl = 1'b1;
      wait_q();
      wait_q();
      m_scl = 1'b0;
      wait_q();
   endtask

   task automatic recv_bit(output logic b);
      m_sda = 1'b1;
      wait_q();
      m_scl = 1'b1;
      wait_q();
      b = sda_bus;
      wait_q();
      m_scl = 1'b0;
      wait_q();
   endtask

   task automatic i2c_start();
      m_sda = 1'b1;
      wait_q();
      m_scl = 1'b1;
      wait_q();
      m_sda = 1'b0;
      wait_q();
      m_scl = 1'b0;
      wait_q();
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0;
      wait_q();
      m_scl = 1'b1;
      wait_q();
      m_sda = 1'b1;
      wait_q();
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic read_byte(input logic nack, output logic [7:0] d);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         recv_bit(b);
         d[i] = b;
      end
      send_bit(nack);
   endtask

   // Host write lands on the 3rd clock edge after SCL falls, i.e. the commit edge.
   task automatic collide_byte(input logic [7:0] d, input logic [3:0] ha,
                               input logic [7:0] hd, output logic ack);
      for (int i = 7; i >= 1; i--) send_bit(d[i]);
      m_sda = d[0];
      wait_q();
      m_scl = 1'b1;
      wait_q();
      wait_q();
      m_scl = 1'b0;
      @(posedge clock);
      @(posedge clock);
      #1;
      host_addr  = ha;
      host_wdata = hd;
      host_we    = 1'b1;
      @(posedge clock);
      #1;
      host_we = 1'b0;
      wait_q();
      recv_bit(ack);
   endtask

   task automatic host_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
      host_addr = a;
      #1;
      chk(name, {24'd0, host_rdata}, {24'd0, exp});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      host_vec_t  vecs[8];
      logic       ack;
      logic       b;
      logic [7:0] d;
      logic       found;

      vecs[0] = '{1'b1, 4'h2, 8'h3C, 8'h3C};
      vecs[1] = '{1'b0, 4'h7, 8'h00, 8'h00};
      vecs[2] = '{1'b1, 4'h1, 8'h6B, 8'h6B};
      vecs[3] = '{1'b1, 4'hF, 8'hFF, 8'hFF};
      vecs[4] = '{1'b1, 4'h7, 8'h9E, 8'h9E};
      vecs[5] = '{1'b0, 4'h2, 8'h00, 8'h3C};
      vecs[6] = '{1'b1, 4'h2, 8'hC4, 8'hC4};
      vecs[7] = '{1'b0, 4'h1, 8'h00, 8'h6B};

      reset      = 1'b1;
      host_we    = 1'b0;
      host_addr  = 4'h0;
      host_wdata = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_wr_strobe", {31'd0, wr_strobe}, 32'd0);
      chk("reset_wr_addr", {28'd0, wr_addr}, 32'd0);
      chk("reset_sda", {31'd0, sda_bus}, 32'd1);
      host_chk("reset_reg0", 4'h0, 8'h00);
      reset = 1'b0;
      wait_q();

      for (int i = 0; i < 8; i++) begin
         host_addr  = vecs[i].addr;
         host_wdata = vecs[i].wdata;
         host_we    = vecs[i].we;
         @(posedge clock);
         #1;
         host_we = 1'b0;
         chk($sformatf("host_vec%0d", i), {24'd0, host_rdata}, {24'd0, vecs[i].exp});
      end

      i2c_start();
      write_byte(8'h22, ack);
      chk("wr_addr_ack", {31'd0, ack}, 32'd0);
      chk("wr_busy", {31'd0, busy}, 32'd1);
      write_byte(8'h03, ack);
      chk("wr_ptr_ack", {31'd0, ack}, 32'd0);
      exp_q.push_back('{4'h3, 8'hA5});
      write_byte(8'hA5, ack);
      chk("wr_d0_ack", {31'd0, ack}, 32'd0);
      exp_q.push_back('{4'h4, 8'h5A});
      write_byte(8'h5A, ack);
      chk("wr_d1_ack", {31'd0, ack}, 32'd0);
      i2c_stop();
      chk("wr_busy_after_stop", {31'd0, busy}, 32'd0);
      host_chk("wr_reg3", 4'h3, 8'hA5);
      host_chk("wr_reg4", 4'h4, 8'h5A);

      i2c_start();
      write_byte(8'h22, ack);
      write_byte(8'h03, ack);
      i2c_start();
      write_byte(8'h23, ack);
      chk("rd_addr_ack", {31'd0, ack}, 32'd0);
      rd_q.push_back(8'hA5);
      rd_q.push_back(8'h5A);
      read_byte(1'b0, d);
      chk("rd_byte0", {24'd0, d}, {24'd0, rd_q.pop_front()});
      read_byte(1'b1, d);
      chk("rd_byte1", {24'd0, d}, {24'd0, rd_q.pop_front()});
      i2c_stop();

      i2c_start();
      write_byte(8'h22, ack);
      write_byte(8'h0F, ack);
      exp_q.push_back('{4'hF, 8'h11});
      write_byte(8'h11, ack);
      exp_q.push_back('{4'h0, 8'h22});
      write_byte(8'h22, ack);
      chk("wrap_ack", {31'd0, ack}, 32'd0);
      i2c_stop();
      host_chk("wrap_reg15", 4'hF, 8'h11);
      host_chk("wrap_reg0", 4'h0, 8'h22);
      i2c_start();
      write_byte(8'h23, ack);
      read_byte(1'b1, d);
      chk("wrap_ptr_is_1", {24'd0, d}, 32'h6B);
      i2c_stop();

      begin
         int sc0;
         sc0 = strobe_cnt;
         nm_watch = 1'b1;
         i2c_start();
         write_byte(8'h40, ack);
         chk("nm_addr_nack", {31'd0, ack}, 32'd1);
         write_byte(8'h55, ack);
         chk("nm_data_nack", {31'd0, ack}, 32'd1);
         i2c_stop();
         nm_watch = 1'b0;
         chk("nm_sda_pulled", {31'd0, nm_pull}, 32'd0);
         chk("nm_busy_seen", {31'd0, nm_busy}, 32'd0);
         chk("nm_strobes", strobe_cnt, sc0);
      end

      i2c_start();
      write_byte(8'h22, ack);
      write_byte(8'h05, ack);
      exp_q.push_back('{4'h5, 8'h99});
      collide_byte(8'h99, 4'h5, 8'h77, ack);
      chk("coll_same_ack", {31'd0, ack}, 32'd0);
      exp_q.push_back('{4'h6, 8'h88});
      collide_byte(8'h88, 4'h9, 8'h44, ack);
      i2c_stop();
      host_chk("coll_reg5_i2c_wins", 4'h5, 8'h99);
      host_chk("coll_reg6", 4'h6, 8'h88);
      host_chk("coll_reg9_host", 4'h9, 8'h44);

      i2c_start();
      write_byte(8'h22, ack);
      write_byte(8'h07, ack);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b0);
      i2c_stop();
      chk("abort_busy", {31'd0, busy}, 32'd0);
      host_chk("abort_reg7", 4'h7, 8'h9E);
      chk("abort_scoreboard", exp_q.size(), 0);

      i2c_start();
      write_byte(8'h23, ack);
      chk("rst_addr_ack", {31'd0, ack}, 32'd0);
      recv_bit(b);
      chk("rst_bit7", {31'd0, b}, 32'd1);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(posedge clock);
         #1;
         if (sda_bus === 1'b0) found = 1'b1;
      end
      chk("rst_bit6_driven_low", {31'd0, found}, 32'd1);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rst_sda_released", {31'd0, sda_bus}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      m_scl = 1'b1;
      m_sda = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      wait_q();
      host_chk("rst_reg7_init", 4'h7, 8'h00);

      chk("total_strobes", strobe_cnt, 6);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
